vdp_bus_master: RTL

VDP_BUS_MASTER -- requirements
Module: vdp_bus_master

---
 rtl/vdp_bus_pkg.sv | 66 ++++++
 rtl/vdp_byte_cycle.sv | 112 +++++++++++
 rtl/vdp_bus_master.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vdp_bus_pkg.sv
// vdp_bus_pkg -- shared types and constants for the VDP bus master.
//
// Contents:
//   op_t      host command opcodes (3 bits)
//   state_t   byte-cycle phase states
//   seq_t     command sequencer states used by vdp_bus_master
//   REG_WRITE_FLAG, ADDR_WRITE_PREFIX, ADDR_READ_PREFIX
//   byte_value()  byte sent to the VDP for a given op and byte index
//   reg_port()    1 when the op talks to the register/address port
//   two_byte()    1 when the op needs two byte writes
package vdp_bus_pkg;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_REG_WRITE    = 3'd1,
        OP_SET_WADDR    = 3'd2,
        OP_SET_RADDR    = 3'd3,
        OP_DATA_WRITE   = 3'd4,
        OP_DATA_READ    = 3'd5,
        OP_STATUS_READ  = 3'd6,
        OP_WAIT_VBLANK  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_READ,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,   // waiting for a command
        SEQ_BYTE,   // a byte cycle is running in vdp_byte_cycle
        SEQ_RESP,   // one-clock read response
        SEQ_END     // one-clock pass for commands without VDP activity
    } seq_t;

    localparam logic [7:0] REG_WRITE_FLAG    = 8'h80;
    localparam logic [1:0] ADDR_WRITE_PREFIX = 2'b01;
    localparam logic [1:0] ADDR_READ_PREFIX  = 2'b00;

    function automatic logic [7:0] byte_value(input op_t op, input logic [13:0] addr,
                                              input logic [7:0] data, input logic idx);
        logic [7:0] b;
        b = 8'h00;
        case (op)
            OP_REG_WRITE:  b = idx ? (REG_WRITE_FLAG | {5'b00000, addr[2:0]}) : data;
            OP_SET_WADDR:  b = idx ? {ADDR_WRITE_PREFIX, addr[13:8]} : addr[7:0];
            OP_SET_RADDR:  b = idx ? {ADDR_READ_PREFIX, addr[13:8]} : addr[7:0];
            OP_DATA_WRITE: b = data;
            default:       b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic reg_port(input op_t op);
        return !((op == OP_DATA_WRITE) || (op == OP_DATA_READ));
    endfunction

    function automatic logic two_byte(input op_t op);
        return (op == OP_REG_WRITE) || (op == OP_SET_WADDR) || (op == OP_SET_RADDR);
    endfunction

endpackage

// File: rtl/vdp_byte_cycle.sv
// vdp_byte_cycle -- generates one VDP byte cycle.
//
// Write: SETUP (1 clk) -> STROBE (1 clk, vdp_wr=1) -> GAP (WR_GAP clks).
// Read:  SETUP (1 clk) -> READ (RD_HOLD clks, vdp_rd=1).
// done is high in the final clock of GAP/READ; a start seen in that clock
// chains straight into the next SETUP, so multi-byte ops have no bubble.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, read, mode,    begin a cycle (sampled in IDLE or while done);
//   wdata                 read/write select, port select, byte to write
//   done                  last clock of the current cycle
//   vdp_mode, vdp_wdata,  VDP-side signals, held stable for the whole cycle
//   vdp_wr, vdp_rd
module vdp_byte_cycle
    import vdp_bus_pkg::*;
#(
    parameter int RD_HOLD = 4,
    parameter int WR_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       read,
    input  logic       mode,
    input  logic [7:0] wdata,
    output logic       done,
    output logic       vdp_mode,
    output logic [7:0] vdp_wdata,
    output logic       vdp_wr,
    output logic       vdp_rd
);

    localparam logic [3:0] RD_LOAD = 4'(RD_HOLD - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_GAP - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       mode_reg, mode_next;
    logic       read_reg, read_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            mode_reg  <= 1'b0;
            read_reg  <= 1'b0;
            wdata_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            read_reg  <= read_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done       = 1'b0;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (read_reg) begin
                    state_next = ST_READ;
                    cnt_next   = RD_LOAD;
                end else begin
                    state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                state_next = ST_GAP;
                cnt_next   = WR_LOAD;
            end
            ST_GAP, ST_READ: begin
                // Count down to zero and stop there; never wraps.
                if (cnt_reg == 4'd0) begin
                    done = 1'b1;
                    if (start) begin
                        load       = 1'b1;
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        mode_next  = load ? mode  : mode_reg;
        read_next  = load ? read  : read_reg;
        wdata_next = load ? wdata : wdata_reg;
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset drops them immediately.
    assign vdp_wr    = (state_reg == ST_STROBE);
    assign vdp_rd    = (state_reg == ST_READ);
    assign vdp_mode  = mode_reg;
    assign vdp_wdata = wdata_reg;

endmodule

// File: rtl/vdp_bus_master.sv
// vdp_bus_master -- host command interface to a VDP-style byte bus.
//
// Accepts one command per IDLE visit (cmd_valid & cmd_ready), latches its
// fields and sequences vdp_byte_cycle through one or two byte cycles.
// Reads return the VDP byte on rsp_data with a one-clock rsp_valid.
// Build option: define VDP_BUS_MASTER_VBLANK_WAIT_EN to make op 7 poll the
// status register until bit 7 is set; otherwise op 7 behaves as NOP.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_op,      command handshake and fields
//   cmd_addr, cmd_data
//   rsp_valid, rsp_data               read response
//   busy                              command in progress
//   vdp_mode, vdp_addr, vdp_wdata,    VDP bus (vdp_addr is tied to 0,
//   vdp_wr, vdp_rd, vdp_rdata         read byte is vdp_rdata[15:8])
module vdp_bus_master
    import vdp_bus_pkg::*;
#(
    parameter int RD_HOLD = 4,
    parameter int WR_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [13:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        vdp_mode,
    output logic [7:0]  vdp_addr,
    output logic [7:0]  vdp_wdata,
    output logic        vdp_wr,
    output logic        vdp_rd,
    input  logic [15:0] vdp_rdata
);

    function automatic logic uses_vdp(input op_t op);
        case (op)
            OP_NOP:         return 1'b0;
`ifdef VDP_BUS_MASTER_VBLANK_WAIT_EN
            OP_WAIT_VBLANK: return 1'b1;
`else
            OP_WAIT_VBLANK: return 1'b0;
`endif
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic is_read(input op_t op);
`ifdef VDP_BUS_MASTER_VBLANK_WAIT_EN
        return (op == OP_DATA_READ) || (op == OP_STATUS_READ) || (op == OP_WAIT_VBLANK);
`else
        return (op == OP_DATA_READ) || (op == OP_STATUS_READ);
`endif
    endfunction

    seq_t        seq_reg, seq_next;
    op_t         op_reg, op_next;
    logic [13:0] addr_reg, addr_next;
    logic [7:0]  data_reg, data_next;
    logic        idx_reg, idx_next;
    logic [7:0]  rsp_data_reg, rsp_data_next;
    logic        started_reg;

    logic        bc_start, bc_read, bc_mode, bc_done;
    logic [7:0]  bc_wdata;
    logic        accept, retry;
    op_t         cmd_op_e;

    logic        unused_rdata_lo;
    assign unused_rdata_lo = ^vdp_rdata[7:0];

    assign cmd_op_e = op_t'(cmd_op);
    assign accept   = cmd_valid && cmd_ready;

    // Vblank wait: a status read without bit 7 set is simply reissued.
`ifdef VDP_BUS_MASTER_VBLANK_WAIT_EN
    assign retry = (op_reg == OP_WAIT_VBLANK) && !vdp_rdata[15];
`else
    assign retry = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_reg      <= SEQ_IDLE;
            op_reg       <= OP_NOP;
            addr_reg     <= 14'h0000;
            data_reg     <= 8'h00;
            idx_reg      <= 1'b0;
            rsp_data_reg <= 8'h00;
            started_reg  <= 1'b0;
        end else begin
            seq_reg      <= seq_next;
            op_reg       <= op_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            idx_reg      <= idx_next;
            rsp_data_reg <= rsp_data_next;
            started_reg  <= 1'b1;
        end
    end

    always_comb begin
        seq_next      = seq_reg;
        op_next       = op_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        idx_next      = idx_reg;
        rsp_data_next = rsp_data_reg;
        bc_start      = 1'b0;
        bc_read       = 1'b0;
        bc_mode       = 1'b0;
        bc_wdata      = 8'h00;
        case (seq_reg)
            SEQ_IDLE: begin
                if (accept) begin
                    op_next   = cmd_op_e;
                    addr_next = cmd_addr;
                    data_next = cmd_data;
                    idx_next  = 1'b0;
                    if (uses_vdp(cmd_op_e)) begin
                        // First byte starts from the live command fields so
                        // SETUP follows acceptance directly.
                        bc_start = 1'b1;
                        bc_read  = is_read(cmd_op_e);
                        bc_mode  = reg_port(cmd_op_e);
                        bc_wdata = byte_value(cmd_op_e, cmd_addr, cmd_data, 1'b0);
                        seq_next = SEQ_BYTE;
                    end else begin
                        seq_next = SEQ_END;
                    end
                end
            end
            SEQ_BYTE: begin
                if (bc_done) begin
                    if (two_byte(op_reg) && !idx_reg) begin
                        bc_start = 1'b1;
                        bc_mode  = 1'b1;
                        bc_wdata = byte_value(op_reg, addr_reg, data_reg, 1'b1);
                        idx_next = 1'b1;
                    end else if (is_read(op_reg)) begin
                        if (retry) begin
                            bc_start = 1'b1;
                            bc_read  = 1'b1;
                            bc_mode  = 1'b1;
                        end else begin
                            rsp_data_next = vdp_rdata[15:8];
                            seq_next      = SEQ_RESP;
                        end
                    end else begin
                        seq_next = SEQ_IDLE;
                    end
                end
            end
            SEQ_RESP: seq_next = SEQ_IDLE;
            SEQ_END:  seq_next = SEQ_IDLE;
            default:  seq_next = SEQ_IDLE;
        endcase
    end

    vdp_byte_cycle #(
        .RD_HOLD (RD_HOLD),
        .WR_GAP  (WR_GAP)
    ) u_byte_cycle (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (bc_start),
        .read      (bc_read),
        .mode      (bc_mode),
        .wdata     (bc_wdata),
        .done      (bc_done),
        .vdp_mode  (vdp_mode),
        .vdp_wdata (vdp_wdata),
        .vdp_wr    (vdp_wr),
        .vdp_rd    (vdp_rd)
    );

    // cmd_ready stays low for the first clock after reset release.
    assign cmd_ready = (seq_reg == SEQ_IDLE) && started_reg;
    assign busy      = (seq_reg != SEQ_IDLE);
    assign rsp_valid = (seq_reg == SEQ_RESP);
    assign rsp_data  = rsp_data_reg;
    assign vdp_addr  = 8'h00;

endmodule
